// File: rtl/mode_sequencer_if.sv
// Button, data and display bundle between the mode sequencer and its surroundings.
// The slave modport is the sequencer's view; the master modport is the driver's view.
interface mode_sequencer_if;
  logic [3:0]  btn_pulse;
  logic        timer_done;
  logic [23:0] data_ch;
  logic [23:0] setup_data;
  logic [23:0] data_t;
  logic [23:0] data_s;
  logic [1:0]  mode;
  logic [2:0]  setup_btn;
  logic [2:0]  timer_btn;
  logic [2:0]  sw_btn;
  logic [23:0] disp_data;
  logic [5:0]  disp_blank;
  logic        alarm_view;

  modport slave (
    input  btn_pulse, timer_done, data_ch, setup_data, data_t, data_s,
    output mode, setup_btn, timer_btn, sw_btn, disp_data, disp_blank, alarm_view
  );

  modport master (
    output btn_pulse, timer_done, data_ch, setup_data, data_t, data_s,
    input  mode, setup_btn, timer_btn, sw_btn, disp_data, disp_blank, alarm_view
  );
endinterface

// File: rtl/mode_sequencer.sv
// View FSM, button router and display mux for the clock/timer/stopwatch design.
// Optional inactivity auto-return to the clock view is enabled by defining AUTO_RETURN_EN.
module mode_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int IDLE_SEC = 30
) (
  input  logic           clock,
  input  logic           reset,
  mode_sequencer_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_CLK = 2'b00,
    ST_SET = 2'b01,
    ST_TMR = 2'b10,
    ST_SW  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        alarm_q, alarm_d;
  logic        td_q, td_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  setup_btn_q, setup_btn_d;
  logic [2:0]  timer_btn_q, timer_btn_d;
  logic [2:0]  sw_btn_q, sw_btn_d;
  logic [23:0] disp_data_q, disp_data_d;
  logic [5:0]  disp_blank_q, disp_blank_d;
  logic        td_edge;
  logic        any_btn;
  logic [2:0]  abc;

  assign td_edge = bus.timer_done & ~td_q;
  assign any_btn = |bus.btn_pulse;
  assign abc     = bus.btn_pulse[3:1];

`ifdef AUTO_RETURN_EN
  localparam int IW = $clog2(IDLE_SEC + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_SEC);
  localparam logic [IW-1:0] IDLE_ONE = IW'(1);
  logic [IW-1:0] idle_q, idle_d;
  logic          sec_tick;
  logic          idle_view;

  assign sec_tick  = (cnt_q == CNT_MAX);
  assign idle_view = (state_q == ST_SET) || (state_q == ST_TMR);
`endif

  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Priority: timer expiry, then alert acknowledge, then mode advance, then A/B/C routing.
  always_comb begin
    state_d     = state_q;
    alarm_d     = alarm_q;
    td_d        = bus.timer_done;
    setup_btn_d = 3'b000;
    timer_btn_d = 3'b000;
    sw_btn_d    = 3'b000;
    if (td_edge) begin
      state_d = ST_TMR;
      alarm_d = 1'b1;
    end else if (alarm_q) begin
      if (any_btn) begin
        alarm_d = 1'b0;
      end else begin
        alarm_d = 1'b1;
      end
    end else if (bus.btn_pulse[0]) begin
      case (state_q)
        ST_CLK:  state_d = ST_SET;
        ST_SET:  state_d = ST_TMR;
        ST_TMR:  state_d = ST_SW;
        ST_SW:   state_d = ST_CLK;
        default: state_d = ST_CLK;
      endcase
    end else if (|abc) begin
      case (state_q)
        ST_SET:  setup_btn_d = abc;
        ST_TMR:  timer_btn_d = abc;
        ST_SW:   sw_btn_d    = abc;
        default: setup_btn_d = 3'b000;
      endcase
    end
`ifdef AUTO_RETURN_EN
    else if (idle_view && (idle_q >= IDLE_MAX)) begin
      state_d = ST_CLK;
    end
`endif
    else begin
      state_d = state_q;
    end
  end

`ifdef AUTO_RETURN_EN
  // Saturating seconds counter; held (not cleared) while an alert is pending.
  always_comb begin
    if (any_btn || (state_d != state_q) || !idle_view) begin
      idle_d = {IW{1'b0}};
    end else if (alarm_q) begin
      idle_d = idle_q;
    end else if (sec_tick && (idle_q < IDLE_MAX)) begin
      idle_d = idle_q + IDLE_ONE;
    end else begin
      idle_d = idle_q;
    end
  end
`endif

  always_comb begin
    case (state_q)
      ST_CLK:  disp_data_d = bus.data_ch;
      ST_SET:  disp_data_d = bus.setup_data;
      ST_TMR:  disp_data_d = bus.data_t;
      ST_SW:   disp_data_d = bus.data_s;
      default: disp_data_d = bus.data_ch;
    endcase
    if (alarm_d && (cnt_d >= CNT_HALF)) begin
      disp_blank_d = 6'b111111;
    end else begin
      disp_blank_d = 6'b000000;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLK;
      alarm_q      <= 1'b0;
      td_q         <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      setup_btn_q  <= 3'b000;
      timer_btn_q  <= 3'b000;
      sw_btn_q     <= 3'b000;
      disp_data_q  <= 24'h000000;
      disp_blank_q <= 6'b000000;
    end else begin
      state_q      <= state_d;
      alarm_q      <= alarm_d;
      td_q         <= td_d;
      cnt_q        <= cnt_d;
      setup_btn_q  <= setup_btn_d;
      timer_btn_q  <= timer_btn_d;
      sw_btn_q     <= sw_btn_d;
      disp_data_q  <= disp_data_d;
      disp_blank_q <= disp_blank_d;
    end
  end

`ifdef AUTO_RETURN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_q <= {IW{1'b0}};
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign bus.mode       = state_q;
  assign bus.alarm_view = alarm_q;
  assign bus.setup_btn  = setup_btn_q;
  assign bus.timer_btn  = timer_btn_q;
  assign bus.sw_btn     = sw_btn_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_blank = disp_blank_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer with TICK_DIV=4, IDLE_SEC=3.
// Define AUTO_RETURN_EN to also exercise the inactivity return.
module tb_mode_sequencer;
  logic clock;
  logic reset;
  int   checks_cnt;
  int   errors_cnt;
  int   ph;
  logic [1:0] cur_mode;

  typedef struct {
    string       tag;
    logic [1:0]  mode;
    logic [2:0]  sb;
    logic [2:0]  tb;
    logic [2:0]  wb;
    logic        alarm;
    logic [5:0]  blank;
    logic [23:0] disp;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [23:0] D_CH = 24'h120000;
  localparam logic [23:0] D_SU = 24'h235959;
  localparam logic [23:0] D_T  = 24'h000530;
  localparam logic [23:0] D_S  = 24'h001234;

  mode_sequencer_if io();

  mode_sequencer #(.TICK_DIV(4), .IDLE_SEC(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (io.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] src(input logic [1:0] m);
    case (m)
      2'd0:    return D_CH;
      2'd1:    return D_SU;
      2'd2:    return D_T;
      default: return D_S;
    endcase
  endfunction

  task automatic pop_check();
    exp_t e;
    e = sb_q.pop_front();
    chk({e.tag, ".mode"},  32'(io.mode),       32'(e.mode));
    chk({e.tag, ".alarm"}, 32'(io.alarm_view), 32'(e.alarm));
    chk({e.tag, ".setup"}, 32'(io.setup_btn),  32'(e.sb));
    chk({e.tag, ".timer"}, 32'(io.timer_btn),  32'(e.tb));
    chk({e.tag, ".sw"},    32'(io.sw_btn),     32'(e.wb));
    chk({e.tag, ".blank"}, 32'(io.disp_blank), 32'(e.blank));
    chk({e.tag, ".disp"},  32'(io.disp_data),  32'(e.disp));
  endtask

  // One clock: drive b/td, predict the post-edge outputs, then compare.
  task automatic cycle(input string tag, input logic [3:0] b, input logic td,
                       input logic [1:0] em, input logic ea,
                       input int rsel, input logic [2:0] rval);
    exp_t e;
    io.btn_pulse  = b;
    io.timer_done = td;
    ph = (ph + 1) % 4;
    e.tag   = tag;
    e.mode  = em;
    e.alarm = ea;
    e.sb    = (rsel == 1) ? rval : 3'b000;
    e.tb    = (rsel == 2) ? rval : 3'b000;
    e.wb    = (rsel == 3) ? rval : 3'b000;
    e.blank = (ea && ph >= 2) ? 6'h3F : 6'h00;
    e.disp  = src(cur_mode);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    io.btn_pulse = 4'b0000;
    cur_mode = em;
    pop_check();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mode"},  32'(io.mode),       32'd0);
    chk({tag, ".alarm"}, 32'(io.alarm_view), 32'd0);
    chk({tag, ".btns"},  32'({io.setup_btn, io.timer_btn, io.sw_btn}), 32'd0);
    chk({tag, ".disp"},  32'(io.disp_data),  32'd0);
    chk({tag, ".blank"}, 32'(io.disp_blank), 32'd0);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    ph = 0;
    cur_mode = 2'd0;
    reset = 1'b1;
    io.btn_pulse  = 4'b0000;
    io.timer_done = 1'b0;
    io.data_ch    = D_CH;
    io.setup_data = D_SU;
    io.data_t     = D_T;
    io.data_s     = D_S;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    cycle("idle0", 4'b0000, 1'b0, 2'd0, 1'b0, 0, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      cycle("mode_adv", 4'b0001, 1'b0, 2'(k % 4), 1'b0, 0, 3'b000);
      for (int j = 0; j < 4; j++) cycle("mode_hold", 4'b0000, 1'b0, 2'(k % 4), 1'b0, 0, 3'b000);
    end

    for (int k = 1; k <= 3; k++) cycle("to_sw", 4'b0001, 1'b0, 2'(k), 1'b0, 0, 3'b000);
    cycle("sw_a", 4'b0010, 1'b0, 2'd3, 1'b0, 3, 3'b001);
    cycle("sw_a_end", 4'b0000, 1'b0, 2'd3, 1'b0, 0, 3'b000);
    cycle("to_clk", 4'b0001, 1'b0, 2'd0, 1'b0, 0, 3'b000);
    cycle("clk_a", 4'b0010, 1'b0, 2'd0, 1'b0, 0, 3'b000);
    cycle("clk_mode_a", 4'b0011, 1'b0, 2'd1, 1'b0, 0, 3'b000);
    cycle("set_c", 4'b1000, 1'b0, 2'd1, 1'b0, 1, 3'b100);
    cycle("set_idle", 4'b0000, 1'b0, 2'd1, 1'b0, 0, 3'b000);

    cycle("td_rise", 4'b0000, 1'b1, 2'd2, 1'b1, 0, 3'b000);
    for (int j = 0; j < 8; j++) cycle("alarm_blink", 4'b0000, 1'b1, 2'd2, 1'b1, 0, 3'b000);
    cycle("td_fall", 4'b0000, 1'b0, 2'd2, 1'b1, 0, 3'b000);
    cycle("td_low", 4'b0000, 1'b0, 2'd2, 1'b1, 0, 3'b000);
    cycle("ack_b", 4'b0100, 1'b0, 2'd2, 1'b0, 0, 3'b000);
    cycle("after_ack", 4'b0000, 1'b0, 2'd2, 1'b0, 0, 3'b000);
    cycle("tmr_b", 4'b0100, 1'b0, 2'd2, 1'b0, 2, 3'b010);
    cycle("to_sw2", 4'b0001, 1'b0, 2'd3, 1'b0, 0, 3'b000);
    cycle("td_and_mode", 4'b0001, 1'b1, 2'd2, 1'b1, 0, 3'b000);
    cycle("ack_mode", 4'b0001, 1'b1, 2'd2, 1'b0, 0, 3'b000);
    cycle("td_clear", 4'b0000, 1'b0, 2'd2, 1'b0, 0, 3'b000);

`ifdef AUTO_RETURN_EN
    begin
      int idle;
      int ret1;
      int ret2;
      bit pressed;
      logic [1:0] nm;
      int nidle;
      cycle("ar_sw", 4'b0001, 1'b0, 2'd3, 1'b0, 0, 3'b000);
      cycle("ar_clk", 4'b0001, 1'b0, 2'd0, 1'b0, 0, 3'b000);
      cycle("ar_set", 4'b0001, 1'b0, 2'd1, 1'b0, 0, 3'b000);
      idle = 0;
      ret1 = -1;
      for (int i = 0; i < 30; i++) begin
        nm = (idle >= 3) ? 2'd0 : cur_mode;
        nidle = (nm != cur_mode || cur_mode == 2'd0 || cur_mode == 2'd3) ? 0 :
                ((ph == 3 && idle < 3) ? idle + 1 : idle);
        if (nm == 2'd0 && cur_mode == 2'd1) ret1 = i;
        cycle("auto_ret", 4'b0000, 1'b0, nm, 1'b0, 0, 3'b000);
        idle = nidle;
      end
      chk("auto_ret_final", 32'(io.mode), 32'd0);

      cycle("ar_set2", 4'b0001, 1'b0, 2'd1, 1'b0, 0, 3'b000);
      idle = 0;
      ret2 = -1;
      pressed = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (!pressed && idle == 2) begin
          pressed = 1'b1;
          cycle("auto_press", 4'b0010, 1'b0, 2'd1, 1'b0, 1, 3'b001);
          idle = 0;
        end else begin
          nm = (idle >= 3) ? 2'd0 : cur_mode;
          nidle = (nm != cur_mode || cur_mode == 2'd0 || cur_mode == 2'd3) ? 0 :
                  ((ph == 3 && idle < 3) ? idle + 1 : idle);
          if (nm == 2'd0 && cur_mode == 2'd1) ret2 = i;
          cycle("auto_ret2", 4'b0000, 1'b0, nm, 1'b0, 0, 3'b000);
          idle = nidle;
        end
      end
      chk("auto_restart_later", 32'(ret2 > ret1 && ret1 >= 0), 32'd1);

      for (int k = 1; k <= 3; k++) cycle("ar_to_sw", 4'b0001, 1'b0, 2'(k), 1'b0, 0, 3'b000);
      for (int i = 0; i < 30; i++) cycle("sw_no_ret", 4'b0000, 1'b0, 2'd3, 1'b0, 0, 3'b000);
      cycle("ar_back0", 4'b0001, 1'b0, 2'd0, 1'b0, 0, 3'b000);
      cycle("ar_back1", 4'b0001, 1'b0, 2'd1, 1'b0, 0, 3'b000);
      cycle("ar_back2", 4'b0001, 1'b0, 2'd2, 1'b0, 0, 3'b000);
    end
`else
    for (int i = 0; i < 30; i++) cycle("tmr_stays", 4'b0000, 1'b0, 2'd2, 1'b0, 0, 3'b000);
`endif

    cycle("alarm_again", 4'b0000, 1'b1, 2'd2, 1'b1, 0, 3'b000);
    cycle("alarm_hold", 4'b0000, 1'b1, 2'd2, 1'b1, 0, 3'b000);
    #3;
    reset = 1'b1;
    io.timer_done = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    ph = 0;
    cur_mode = 2'd0;
    cycle("post_rst", 4'b0000, 1'b0, 2'd0, 1'b0, 0, 3'b000);
    cycle("post_rst2", 4'b0000, 1'b0, 2'd0, 1'b0, 0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
